// File: rtl/ps_pkg.sv
// Shared constants for the pixel-processing pipeline: luma coefficients,
// pixel widths and the input read FSM encoding.
package ps_pkg;

  localparam int RGB_W  = 12;
  localparam int GREY_W = 8;
  localparam int CH_W   = 4;
  localparam int PROD_W = 16;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rd_state_e;

  // Replicating the 4-bit channel gives the exact 0..255 range ({C,C} == C*17).
  function automatic logic [PROD_W-1:0] luma_term(input logic [CH_W-1:0] ch,
                                                  input logic [7:0]      coef);
    return PROD_W'({ch, ch}) * PROD_W'(coef);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO with occupancy and almost flags.
// A simultaneous read and write leaves the fill unchanged, even when full or empty.
module fifo_sync #(
  parameter int DATA_WIDTH         = 12,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOSTFULL_OFFSET  = 4,
  parameter int ALMOSTEMPTY_OFFSET = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clear,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_full,
  output logic                  o_almostfull,
  output logic                  o_empty,
  output logic                  o_almostempty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(DEPTH - ALMOSTFULL_OFFSET);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH+1)'(ALMOSTEMPTY_OFFSET);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign o_fill        = r_fill;
  assign o_full        = (r_fill == FULL_LVL);
  assign o_empty       = (r_fill == '0);
  assign o_almostfull  = (r_fill >= AF_LVL);
  assign o_almostempty = (r_fill <= AE_LVL);
  assign o_rdata       = o_empty ? '0 : r_mem[r_rptr];

  assign w_do_wr = i_wr && (!o_full  || i_rd);
  assign w_do_rd = i_rd && (!o_empty || i_wr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty gate on o_rdata hides stale words,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/ps_rgb2grey.sv
// Two-stage RGB444 -> 8-bit luma datapath carrying valid/enable/raw pixel alongside.
// PS_GREYSCALE_ROUND_EN adds a round-half-up bias before the final shift.
module ps_rgb2grey
  import ps_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_enable,
  input  logic [RGB_W-1:0]  i_pixel,
  output logic              o_valid,
  output logic              o_enable,
  output logic [RGB_W-1:0]  o_pixel,
  output logic [GREY_W-1:0] o_grey
);

`ifdef PS_GREYSCALE_ROUND_EN
  localparam logic [PROD_W-1:0] ROUND_BIAS = PROD_W'(128);
`else
  localparam logic [PROD_W-1:0] ROUND_BIAS = '0;
`endif

  logic              r_s1_valid, r_s1_en;
  logic [RGB_W-1:0]  r_s1_pixel;
  logic [PROD_W-1:0] r_s1_pr, r_s1_pg, r_s1_pb;
  logic              r_s2_valid, r_s2_en;
  logic [RGB_W-1:0]  r_s2_pixel;
  logic [GREY_W-1:0] r_s2_grey;
  logic [PROD_W-1:0] w_sum;

  // Worst case 65280 + 128 still fits in PROD_W bits.
  assign w_sum = r_s1_pr + r_s1_pg + r_s1_pb + ROUND_BIAS;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_valid    && !i_flush;
      r_s2_valid <= r_s1_valid && !i_flush;
    end
  end

  always_ff @(posedge i_clk) begin
    r_s1_en    <= i_enable;
    r_s1_pixel <= i_pixel;
    r_s1_pr    <= luma_term(i_pixel[RGB_W-1 -: CH_W],  COEF_R);
    r_s1_pg    <= luma_term(i_pixel[2*CH_W-1 -: CH_W], COEF_G);
    r_s1_pb    <= luma_term(i_pixel[CH_W-1:0],         COEF_B);
    r_s2_en    <= r_s1_en;
    r_s2_pixel <= r_s1_pixel;
    r_s2_grey  <= w_sum[PROD_W-1 -: GREY_W];
  end

  assign o_valid  = r_s2_valid;
  assign o_enable = r_s2_en;
  assign o_pixel  = r_s2_pixel;
  assign o_grey   = r_s2_grey;

endmodule

// File: rtl/ps_greyscale_top.sv
// Greyscale stage: input read FSM, luma pipeline, passthrough mux, output buffer.
// Build option PS_GREYSCALE_ROUND_EN selects rounding in the luma pipeline.
module ps_greyscale_top
  import ps_pkg::*;
#(
  parameter int OBUF_ADDR_WIDTH         = 4,
  parameter int OBUF_ALMOSTFULL_OFFSET  = 4,
  parameter int OBUF_ALMOSTEMPTY_OFFSET = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic [RGB_W-1:0]         i_data,
  input  logic                     i_almostempty,
  output logic                     o_rd,
  input  logic                     i_obuf_rd,
  output logic [RGB_W-1:0]         o_obuf_data,
  output logic [OBUF_ADDR_WIDTH:0] o_obuf_fill,
  output logic                     o_obuf_full,
  output logic                     o_obuf_almostfull,
  output logic                     o_obuf_empty,
  output logic                     o_obuf_almostempty
);

  rd_state_e         r_state;
  logic              w_can_read;
  logic              w_s2_valid, w_s2_en;
  logic [RGB_W-1:0]  w_s2_pixel;
  logic [GREY_W-1:0] w_s2_grey;
  logic [RGB_W-1:0]  w_wdata;

  assign w_can_read = !i_almostempty && !o_obuf_almostfull;

  // i_flush deliberately leaves the FSM alone; only the datapath is cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      o_rd    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_rd <= w_can_read;
          if (w_can_read) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          o_rd <= w_can_read;
          if (!w_can_read) r_state <= ST_IDLE;
        end
        default: begin
          o_rd    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  ps_rgb2grey u_rgb2grey (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_flush  (i_flush),
    .i_valid  (o_rd),
    .i_enable (i_enable),
    .i_pixel  (i_data),
    .o_valid  (w_s2_valid),
    .o_enable (w_s2_en),
    .o_pixel  (w_s2_pixel),
    .o_grey   (w_s2_grey)
  );

  assign w_wdata = w_s2_en ? {w_s2_grey, 4'b0000} : w_s2_pixel;

  fifo_sync #(
    .DATA_WIDTH         (RGB_W),
    .ADDR_WIDTH         (OBUF_ADDR_WIDTH),
    .ALMOSTFULL_OFFSET  (OBUF_ALMOSTFULL_OFFSET),
    .ALMOSTEMPTY_OFFSET (OBUF_ALMOSTEMPTY_OFFSET)
  ) u_obuf (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_clear       (i_flush),
    .i_wr          (w_s2_valid && !i_flush),
    .i_wdata       (w_wdata),
    .i_rd          (i_obuf_rd),
    .o_rdata       (o_obuf_data),
    .o_fill        (o_obuf_fill),
    .o_full        (o_obuf_full),
    .o_almostfull  (o_obuf_almostfull),
    .o_empty       (o_obuf_empty),
    .o_almostempty (o_obuf_almostempty)
  );

endmodule

// File: tb/tb_ps_greyscale_top.sv
// Self-checking bench for ps_greyscale_top: a queue-based buffer model is compared
// every cycle, plus literal expected words for the directed pixel vectors.
module tb_ps_greyscale_top;

  localparam int AW    = 4;
  localparam int AF    = 4;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_flush = 1'b0;
  logic [11:0]   i_data = 12'h000;
  logic          i_almostempty = 1'b1;
  logic          o_rd;
  logic          i_obuf_rd = 1'b0;
  logic [11:0]   o_obuf_data;
  logic [AW:0]   o_obuf_fill;
  logic          o_obuf_full, o_obuf_almostfull, o_obuf_empty, o_obuf_almostempty;

  ps_greyscale_top #(
    .OBUF_ADDR_WIDTH(AW), .OBUF_ALMOSTFULL_OFFSET(AF), .OBUF_ALMOSTEMPTY_OFFSET(AE)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_flush(i_flush),
    .i_data(i_data), .i_almostempty(i_almostempty), .o_rd(o_rd),
    .i_obuf_rd(i_obuf_rd), .o_obuf_data(o_obuf_data), .o_obuf_fill(o_obuf_fill),
    .o_obuf_full(o_obuf_full), .o_obuf_almostfull(o_obuf_almostfull),
    .o_obuf_empty(o_obuf_empty), .o_obuf_almostempty(o_obuf_almostempty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] w;
    int          t;
  } pend_t;

  pend_t       pend[$];
  logic [11:0] bq[$];
  logic [11:0] got[$];
  logic [11:0] src[$];
  logic        src_en[$];
  int          idx = 0;
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          rd_mode = 0;
  bit          gate = 1'b1;
  bit          toggle_ae = 1'b0;
  logic        exp_rd = 1'b0;
  logic        exp_next;
  logic [11:0] cap_w;
  logic [11:0] m_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Spec-level luma: channel scaled to 0..255 by *17, weighted sum, divide by 256.
  function automatic logic [11:0] exp_word(input logic [11:0] p, input logic en);
    int r, g, b, s;
    r = int'(p[11:8]) * 17;
    g = int'(p[7:4]) * 17;
    b = int'(p[3:0]) * 17;
    s = r * 77 + g * 150 + b * 29;
`ifdef PS_GREYSCALE_ROUND_EN
    s = s + 128;
`endif
    if (!en) return p;
    return {8'(s / 256), 4'h0};
  endfunction

  // Per-cycle compare against the model, then advance the model by one clock.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      check("reset_rd", o_rd, 0);
      check("reset_fill", o_obuf_fill, 0);
      check("reset_empty", o_obuf_empty, 1);
      check("reset_almostempty", o_obuf_almostempty, 1);
      check("reset_full", o_obuf_full, 0);
      check("reset_almostfull", o_obuf_almostfull, 0);
      check("reset_data", o_obuf_data, 0);
      bq.delete();
      pend.delete();
      exp_rd = 1'b0;
    end else begin
      m_head = (bq.size() > 0) ? bq[0] : 12'h000;
      check("o_rd", o_rd, exp_rd);
      check("fill", o_obuf_fill, bq.size());
      check("empty", o_obuf_empty, bq.size() == 0);
      check("almostempty", o_obuf_almostempty, bq.size() <= AE);
      check("full", o_obuf_full, bq.size() == DEPTH);
      check("almostfull", o_obuf_almostfull, bq.size() >= DEPTH - AF);
      check("data", o_obuf_data, m_head);
      exp_next = !i_almostempty && !(bq.size() >= DEPTH - AF);
      if (i_obuf_rd && bq.size() > 0) got.push_back(o_obuf_data);
      if (o_rd) begin
        cap_w = exp_word(i_data, i_enable);
        idx++;
      end
      if (i_flush) begin
        bq.delete();
        pend.delete();
      end else begin
        if (i_obuf_rd && bq.size() > 0) void'(bq.pop_front());
        while (pend.size() > 0 && pend[0].t == cyc + 1) begin
          check("no_write_when_full", bq.size() < DEPTH, 1);
          bq.push_back(pend[0].w);
          void'(pend.pop_front());
        end
        if (o_rd) pend.push_back('{cap_w, cyc + 3});
      end
      exp_rd = exp_next;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_flush       = 1'b0;
    i_data        = (idx < src.size()) ? src[idx] : 12'h000;
    i_enable      = (idx < src.size()) ? src_en[idx] : 1'b0;
    i_almostempty = gate || (src.size() - idx <= 1) || (toggle_ae && ((cyc / 3) % 2 == 1));
    i_obuf_rd     = !o_obuf_empty && (rd_mode == 1 || (rd_mode == 2 && cyc % 2 == 0));
  endtask

  task automatic clear_src();
    src.delete();
    src_en.delete();
    got.delete();
    idx = 0;
  endtask

  task automatic add(input logic [11:0] p, input logic en);
    src.push_back(p);
    src_en.push_back(en);
  endtask

  // Read the source down to its pad pixel, then stop and drain the buffer.
  task automatic run_phase(input int max_cyc);
    int n;
    n = 0;
    gate = 1'b0;
    while ((src.size() - idx) > 1 && n < max_cyc) begin tick(); n++; end
    check("source_consumed_in_time", n < max_cyc, 1);
    gate = 1'b1;
    if (rd_mode == 0) rd_mode = 1;
    n = 0;
    while ((pend.size() != 0 || bq.size() != 0 || o_rd) && n < max_cyc) begin tick(); n++; end
    check("drained_in_time", n < max_cyc, 1);
  endtask

  logic [11:0] lit_a [6];
  logic [11:0] lit_c [2];

  initial begin
`ifdef PS_GREYSCALE_ROUND_EN
    lit_a = '{12'h4D0, 12'h950, 12'h1D0, 12'hFF0, 12'h880, 12'h000};
    lit_c = '{12'h4D0, 12'hF00};
`else
    lit_a = '{12'h4C0, 12'h950, 12'h1C0, 12'hFF0, 12'h880, 12'h000};
    lit_c = '{12'h4C0, 12'hF00};
`endif
    repeat (3) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    repeat (3) tick();

    // Conversion of primary and grey pixels.
    clear_src();
    add(12'hF00, 1); add(12'h0F0, 1); add(12'h00F, 1);
    add(12'hFFF, 1); add(12'h888, 1); add(12'h000, 1);
    add(12'h000, 1);
    rd_mode = 1;
    run_phase(200);
    check("convA_count", got.size() >= 6, 1);
    for (int i = 0; i < 6; i++) check($sformatf("convA_%0d", i), got[i], lit_a[i]);

    // Passthrough.
    clear_src();
    add(12'h123, 0); add(12'hABC, 0); add(12'h000, 0);
    run_phase(200);
    check("pass_0", got[0], 12'h123);
    check("pass_1", got[1], 12'hABC);

    // Enable toggled between consecutive reads of the same pixel.
    clear_src();
    add(12'hF00, 1); add(12'hF00, 0); add(12'h000, 0);
    run_phase(200);
    for (int i = 0; i < 2; i++) check($sformatf("toggle_%0d", i), got[i], lit_c[i]);

    // Backpressure: no downstream reads, then resume.
    clear_src();
    for (int i = 0; i < 40; i++) add(12'((i * 97 + 5) % 4096), i[0]);
    add(12'h000, 0);
    rd_mode = 0;
    gate = 1'b0;
    repeat (60) tick();
    check("bp_fill_hold", o_obuf_fill, 15);
    check("bp_consumed", idx, 15);
    rd_mode = 1;
    run_phase(400);
    check("bp_count", got.size() >= 40, 1);
    for (int i = 0; i < 40; i++) check($sformatf("bp_%0d", i), got[i], exp_word(src[i], src_en[i]));

    // Bouncing almost-empty with sparse downstream reads.
    clear_src();
    for (int i = 0; i < 20; i++) add(12'(12'h100 + i), 0);
    add(12'h000, 0);
    toggle_ae = 1'b1;
    rd_mode = 2;
    run_phase(400);
    toggle_ae = 1'b0;
    for (int i = 0; i < 20; i++) check($sformatf("seq_%0d", i), got[i], 12'(12'h100 + i));

    // Flush with 5 buffered and 2 in flight.
    clear_src();
    for (int i = 0; i < 30; i++) add(12'(i * 131), 1);
    rd_mode = 0;
    gate = 1'b0;
    begin
      int n;
      n = 0;
      while (o_obuf_fill != 5 && n < 100) begin tick(); n++; end
      check("flush_setup_in_time", n < 100, 1);
    end
    i_flush = 1'b1;
    tick();
    check("flush_fill", o_obuf_fill, 0);
    check("flush_empty", o_obuf_empty, 1);
    rd_mode = 1;
    run_phase(400);

    clear_src();
    add(12'hF00, 1); add(12'h0F0, 1); add(12'h000, 1);
    run_phase(200);
    check("post_flush_0", got[0], lit_a[0]);
    check("post_flush_1", got[1], lit_a[1]);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/ps_greyscale_top.md
# ps_greyscale_top

Colour-to-luma conversion stage of the pixel-processing pipeline. It drains the camera input FIFO (RGB444), converts each pixel to 8-bit greyscale through a 2-stage pipelined multiplier, and writes the result into a local output buffer. That buffer is read by the Gaussian stage as its `i_data`/`i_almostempty`, with greyscale placed in bits [11:4]. When disabled, pixels pass through unchanged with identical latency.

## Interface
Parameters:
- OBUF_ADDR_WIDTH, 4, output buffer depth = 2**OBUF_ADDR_WIDTH entries.
- OBUF_ALMOSTFULL_OFFSET, 4, almost-full threshold; must be ≥ pipeline depth + 1.
- OBUF_ALMOSTEMPTY_OFFSET, 2, almost-empty threshold seen by the downstream stage.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset: synchronous, active-low; clock i_clk.
- i_enable  in  1  1 = convert to greyscale, 0 = passthrough.
- i_flush  in  1  synchronous clear of the pipeline and output buffer; the FSM is not cleared.
- i_data  in  12  input pixel {R[3:0],G[3:0],B[3:0]}; show-ahead FIFO, so valid in the cycle o_rd is high.
- i_almostempty  in  1  input FIFO almost empty.
- o_rd  out  1  registered input FIFO read strobe.
- i_obuf_rd  in  1  downstream read of the output buffer.
- o_obuf_data  out  12  buffer head.
- o_obuf_fill  out  OBUF_ADDR_WIDTH+1  buffer occupancy.
- o_obuf_full, o_obuf_almostfull, o_obuf_empty, o_obuf_almostempty  out  1 each  buffer flags.

## Operation
- Read FSM, two states:
  - IDLE→ACTIVE when !i_almostempty && !o_obuf_almostfull; o_rd is asserted on the next edge.
  - In ACTIVE, o_rd = !i_almostempty && !o_obuf_almostfull; any failure returns the FSM to IDLE.
- S0 (o_rd high) captures i_data together with i_enable. The captured enable bit travels with the pixel, so toggling i_enable mid-stream never reorders or mixes pixels.
- Channel expansion: r8={R,R}, g8={G,G}, b8={B,B}.
- S1 registers the products r8·77, g8·150, b8·29, each 16 bits unsigned.
- S2 registers Y = (sum [+128 if rounding]) >> 8, truncated to 8 bits. The maximum sum of 65408 fits in 16 bits, so there is no overflow.
- Buffer write data is {Y,4'b0} for a converting pixel, or the original 12-bit pixel for a passthrough pixel.
- Buffer write occurs in the cycle S2 holds a valid pixel.
- Writes to a full buffer are forbidden. Backpressure through the almost-full threshold guarantees this; the bench asserts it.
- Simultaneous buffer read and write when full or empty: follow fifo_sync semantics (fill unchanged).
- i_flush: clears S1/S2 valid bits and empties the buffer in the same cycle. An o_rd issued in the flush cycle is discarded.
- Reset values: o_rd=0, FSM=IDLE, pipeline valids=0, o_obuf_fill=0, o_obuf_empty=1, o_obuf_almostempty=1, o_obuf_full=0, o_obuf_almostfull=0, o_obuf_data=0.

## Timing
- Cycle N: o_rd high, pixel captured.
- N+1: products valid.
- N+2: Y valid, buffer write.
- N+3: pixel visible in the buffer (o_obuf_empty falls if the buffer was empty).
- o_rd responds to i_almostempty and o_obuf_almostfull one cycle late (registered).
- Sustained throughput is 1 pixel/clock while neither flag is set.
- Up to 3 pixels are in flight when almost-full asserts. OBUF_ALMOSTFULL_OFFSET ≥ 4 covers this.

## Configuration
- Macro: PS_GREYSCALE_ROUND_EN.
- Defined: S2 adds 128 before the shift (round-half-up).
- Undefined: plain truncation.
- The macro has no effect on latency, ports or passthrough pixels.

## Structure
- Shared package ps_pkg holds:
  - Luma coefficients (77, 150, 29).
  - Pixel width constants (RGB444 = 12, grey = 8).
  - The FSM state encoding (IDLE, ACTIVE).
- Sub-module ps_rgb2grey holds the S1/S2 arithmetic and the valid/enable sideband pipeline.
- The top holds the FSM, passthrough mux and fifo_sync instance.

## Test plan
- Enable=1, pixels F00, 0F0, 00F, FFF, 888, 000 → buffer words 0x4C0, 0x950, 0x1C0, 0xFF0, 0x880, 0x000. With PS_GREYSCALE_ROUND_EN, F00 → 0x4D0.
- Enable=0, stream 0x123, 0xABC → identical words, each arriving 3 cycles after its o_rd.
- Toggle i_enable between consecutive reads of 0xF00 and 0xF00 → buffer holds 0x4C0 then 0xF00, in order.
- Downstream never reads, 40 pixels offered → o_rd drops within 1 cycle of almost-full, o_obuf_full may set, no write while full, no pixel lost once reads resume.
- i_almostempty toggling every 3 cycles → FSM bounces IDLE/ACTIVE, no duplicate or dropped pixels (sequence check).
- i_flush with 2 pixels in flight and 5 buffered → next cycle fill=0 and empty=1; subsequent pixels convert correctly.
